// File: rtl/ace_pkg.sv
// Shared ACE snoop encodings, CRRESP bit positions and line-state update opcodes.
package ace_pkg;

   localparam logic [3:0] SnpReadOnce           = 4'b0000;
   localparam logic [3:0] SnpReadShared         = 4'b0001;
   localparam logic [3:0] SnpReadClean          = 4'b0010;
   localparam logic [3:0] SnpReadNotSharedDirty = 4'b0011;
   localparam logic [3:0] SnpReadUnique         = 4'b0111;
   localparam logic [3:0] SnpCleanShared        = 4'b1000;
   localparam logic [3:0] SnpCleanInvalid       = 4'b1001;
   localparam logic [3:0] SnpMakeInvalid        = 4'b1101;

   localparam int unsigned CrDataTransfer = 0;
   localparam int unsigned CrError        = 1;
   localparam int unsigned CrPassDirty    = 2;
   localparam int unsigned CrIsShared     = 3;
   localparam int unsigned CrWasUnique    = 4;

   typedef enum logic [1:0] {
      UpdShared      = 2'd0,
      UpdSharedClean = 2'd1,
      UpdInvalid     = 2'd2,
      UpdClean       = 2'd3
   } upd_op_e;

   function automatic logic snoop_supported(input logic [3:0] snoop);
      case (snoop)
         SnpReadOnce, SnpReadShared, SnpReadClean, SnpReadNotSharedDirty,
         SnpReadUnique, SnpCleanShared, SnpCleanInvalid, SnpMakeInvalid: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ace_snoop_decode.sv
// Maps a snoop type and the looked-up line state to CRRESP, data transfer and state update.
module ace_snoop_decode
   import ace_pkg::*;
(
   input  logic [3:0] snoop_i,
   input  logic       hit_i,
   input  logic       dirty_i,
   input  logic       shared_i,
   output logic [4:0] cr_resp_o,
   output logic       data_transfer_o,
   output logic       upd_en_o,
   output upd_op_e    upd_op_o
);

   always_comb begin
      cr_resp_o = '0;
      upd_en_o  = 1'b0;
      upd_op_o  = UpdShared;
      if (hit_i) begin
         cr_resp_o[CrWasUnique] = ~shared_i;
         case (snoop_i)
            SnpReadOnce: begin
               cr_resp_o[CrDataTransfer] = 1'b1;
               cr_resp_o[CrIsShared]     = 1'b1;
            end
            SnpReadShared, SnpReadNotSharedDirty: begin
               cr_resp_o[CrDataTransfer] = 1'b1;
               cr_resp_o[CrIsShared]     = 1'b1;
               cr_resp_o[CrPassDirty]    = dirty_i;
               upd_en_o                  = 1'b1;
               upd_op_o                  = dirty_i ? UpdSharedClean : UpdShared;
            end
            SnpReadClean: begin
               // Ownership of the dirty data stays here, so only the shared bit changes.
               cr_resp_o[CrDataTransfer] = 1'b1;
               cr_resp_o[CrIsShared]     = 1'b1;
               upd_en_o                  = 1'b1;
               upd_op_o                  = UpdShared;
            end
            SnpReadUnique: begin
               cr_resp_o[CrDataTransfer] = 1'b1;
               cr_resp_o[CrPassDirty]    = dirty_i;
               upd_en_o                  = 1'b1;
               upd_op_o                  = UpdInvalid;
            end
            SnpCleanInvalid: begin
               cr_resp_o[CrDataTransfer] = dirty_i;
               cr_resp_o[CrPassDirty]    = dirty_i;
               upd_en_o                  = 1'b1;
               upd_op_o                  = UpdInvalid;
            end
            SnpCleanShared: begin
               cr_resp_o[CrIsShared] = 1'b1;
               if (dirty_i) begin
                  cr_resp_o[CrDataTransfer] = 1'b1;
                  cr_resp_o[CrPassDirty]    = 1'b1;
                  upd_en_o                  = 1'b1;
                  upd_op_o                  = UpdClean;
               end
            end
            SnpMakeInvalid: begin
               upd_en_o = 1'b1;
               upd_op_o = UpdInvalid;
            end
            default: cr_resp_o = '0;
         endcase
      end
   end

   assign data_transfer_o = cr_resp_o[CrDataTransfer];

endmodule

// File: rtl/ace_snoop_responder.sv
// Single-outstanding ACE snoop responder: AC accept, tag lookup, CR response, CD stream,
// then line-state update.
module ace_snoop_responder
   import ace_pkg::*;
#(
   parameter int unsigned AddrWidth = 64,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned CdBeats   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ac_valid_i,
   output logic                 ac_ready_o,
   input  logic [AddrWidth-1:0] ac_addr_i,
   input  logic [3:0]           ac_snoop_i,
   output logic                 cr_valid_o,
   input  logic                 cr_ready_i,
   output logic [4:0]           cr_resp_o,
   output logic                 cd_valid_o,
   input  logic                 cd_ready_i,
   output logic [DataWidth-1:0] cd_data_o,
   output logic                 cd_last_o,
   output logic                 lu_valid_o,
   input  logic                 lu_ready_i,
   output logic [AddrWidth-1:0] lu_addr_o,
   input  logic                 lu_resp_valid_i,
   input  logic                 lu_hit_i,
   input  logic                 lu_dirty_i,
   input  logic                 lu_shared_i,
   input  logic                 dat_valid_i,
   output logic                 dat_ready_o,
   input  logic [DataWidth-1:0] dat_i,
   output logic                 upd_valid_o,
   input  logic                 upd_ready_i,
   output logic [1:0]           upd_op_o
);

   localparam int unsigned CntW = $clog2(CdBeats);
   localparam logic [CntW-1:0] LastBeat = CntW'(CdBeats - 1);

   typedef enum logic [2:0] {StIdle, StLookup, StLuWait, StResp, StData, StUpd} state_e;

   state_e               state_q;
   logic [AddrWidth-1:0] addr_q;
   logic [3:0]           snoop_q;
   logic                 err_q, hit_q, dirty_q, shared_q;
   logic [CntW-1:0]      cnt_q;

   logic [4:0] dec_resp;
   logic       dec_dt, dec_upd_en;
   upd_op_e    dec_op;
   logic       live, in_data, cd_fire;

   ace_snoop_decode u_decode (
      .snoop_i         (snoop_q),
      .hit_i           (hit_q),
      .dirty_i         (dirty_q),
      .shared_i        (shared_q),
      .cr_resp_o       (dec_resp),
      .data_transfer_o (dec_dt),
      .upd_en_o        (dec_upd_en),
      .upd_op_o        (dec_op)
   );

   assign in_data = (state_q == StData);
   assign cd_fire = in_data && dat_valid_i && cd_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         snoop_q  <= '0;
         err_q    <= 1'b0;
         hit_q    <= 1'b0;
         dirty_q  <= 1'b0;
         shared_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ac_valid_i) begin
                  addr_q   <= ac_addr_i;
                  snoop_q  <= ac_snoop_i;
                  hit_q    <= 1'b0;
                  dirty_q  <= 1'b0;
                  shared_q <= 1'b0;
                  err_q    <= ~snoop_supported(ac_snoop_i);
                  state_q  <= snoop_supported(ac_snoop_i) ? StLookup : StResp;
               end
            end
            StLookup: if (lu_ready_i) state_q <= StLuWait;
            StLuWait: begin
               if (lu_resp_valid_i) begin
                  hit_q    <= lu_hit_i;
                  dirty_q  <= lu_dirty_i;
                  shared_q <= lu_shared_i;
                  state_q  <= StResp;
               end
            end
            StResp: begin
               // Unsupported snoops never set hit_q, so the decoder requests nothing.
               if (cr_ready_i) begin
                  if (dec_dt)          state_q <= StData;
                  else if (dec_upd_en) state_q <= StUpd;
                  else                 state_q <= StIdle;
               end
            end
            StData: begin
               if (cd_fire) begin
                  if (cnt_q == LastBeat) begin
                     cnt_q   <= '0;
                     state_q <= dec_upd_en ? StUpd : StIdle;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
            end
            StUpd: if (upd_ready_i) state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Outputs are forced low while reset is asserted, not just after the reset edge.
   assign live = ~rst_i;

   assign ac_ready_o  = live && (state_q == StIdle);
   assign lu_valid_o  = live && (state_q == StLookup);
   assign lu_addr_o   = live ? addr_q : '0;
   assign cr_valid_o  = live && (state_q == StResp);
   assign cr_resp_o   = (live && state_q == StResp) ?
                        (err_q ? 5'(1 << CrError) : dec_resp) : '0;
   assign cd_valid_o  = live && in_data && dat_valid_i;
   assign dat_ready_o = live && in_data && cd_ready_i;
   assign cd_data_o   = (live && in_data) ? dat_i : '0;
   assign cd_last_o   = live && in_data && (cnt_q == LastBeat);
   assign upd_valid_o = live && (state_q == StUpd);
   assign upd_op_o    = (live && state_q == StUpd) ? dec_op : UpdShared;

endmodule
